piso_stream: RTL

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, per-word frame length, runtime bit order and an external bit-rate strobe. It is the next-generation shifter for the USART transmit path, sitting between the TX FIFO and the line driver. It supports back-to-back words with no idle gap and flags the end of every frame.

---
 rtl/piso_pkg.sv | 25 ++
 rtl/piso_bit_cnt.sv | 30 +++
 rtl/piso_stream.sv | 121 ++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and helpers for the piso_stream serializer
package piso_pkg;

    // Two-state shifter: waiting for a word, or shifting one out
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } piso_state_t;

    // Ceiling log2, used to size the length port and bit counter
    function automatic int piso_clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // A length of 0 or anything wider than the word means a full word
    function automatic int piso_norm_len(input int len, input int width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// rtl/piso_bit_cnt.sv - loadable down-counter of bits remaining in a frame
module piso_bit_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             s_rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             last_o
);

    logic [CNT_W-1:0] r_count;

    // Load wins over decrement so a back-to-back reload starts a fresh count
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= load_val_i;
        end else if (dec_i && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign count_o = r_count;
    assign last_o  = (r_count == CNT_W'(1));

endmodule

// File: rtl/piso_stream.sv
// rtl/piso_stream.sv - parallel-in/serial-out shifter with load handshake and bit strobe
module piso_stream
    import piso_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter logic IDLE_LEVEL = 1'b1,
    parameter int   LEN_W      = piso_clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  s_rst_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic                  msb_first_i,
    input  logic                  tick_i,
    output logic                  data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    piso_state_t           r_state;
    piso_state_t           w_next_state;
    logic [DATA_WIDTH-1:0] r_sreg;
    logic                  r_msb_first;
    logic                  r_done;

    logic [LEN_W-1:0]      w_len;
    logic [LEN_W-1:0]      w_shamt;
    logic [LEN_W-1:0]      w_count;
    logic                  w_last;
    logic                  w_shift_tick;
    logic                  w_frame_end;
    logic                  w_accept;

    assign w_len   = LEN_W'(piso_norm_len(int'(len_i), DATA_WIDTH));
    assign w_shamt = LEN_W'(DATA_WIDTH) - w_len;

    assign w_shift_tick = (r_state == ST_SHIFT) && tick_i;
    assign w_frame_end  = w_shift_tick && w_last;

    // Ready during the final tick lets the next word load with no idle gap
    assign s_ready_o = (r_state == ST_IDLE) || w_frame_end;
    assign w_accept  = s_valid_i && s_ready_o;

    piso_bit_cnt #(
        .CNT_W (LEN_W)
    ) u_bit_cnt (
        .clk_i      (clk_i),
        .s_rst_i    (s_rst_i),
        .load_i     (w_accept),
        .load_val_i (w_len),
        .dec_i      (w_shift_tick),
        .count_o    (w_count),
        .last_o     (w_last)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: a reload on the last tick keeps the block in SHIFT
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_frame_end) begin
                    w_next_state = w_accept ? ST_SHIFT : ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Shift register: MSB mode left-aligns the word so bit len-1 leads
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            r_sreg      <= '0;
            r_msb_first <= 1'b0;
        end else if (w_accept) begin
            r_sreg      <= msb_first_i ? (data_i << w_shamt) : data_i;
            r_msb_first <= msb_first_i;
        end else if (w_shift_tick) begin
            if (r_msb_first) begin
                r_sreg <= {r_sreg[DATA_WIDTH-2:0], 1'b0};
            end else begin
                r_sreg <= {1'b0, r_sreg[DATA_WIDTH-1:1]};
            end
        end
    end

    // End-of-frame pulse, one cycle after the final tick
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_frame_end;
        end
    end

    // Serial output comes only from registers, so tick_i cannot glitch it
    always_comb begin
        busy_o = (r_state == ST_SHIFT);
        done_o = r_done;
        data_o = IDLE_LEVEL;
        if (busy_o) begin
            data_o = r_msb_first ? r_sreg[DATA_WIDTH-1] : r_sreg[0];
        end
    end

endmodule
